tff_timer_ctrl: RTL and testbench

Programmable down-counting timer built from a chain of loadable toggle cells, plus the controller that sequences them. The controller generates each cell's enable (toggle) and load/data controls so the chain loads a preload value, counts down once per clock, and signals expiry. It serves as the shared interval timer next to the flip-flop library cells, in one-shot or auto-reload mode.

---
 rtl/tff_timer_ctrl_pkg.sv | 18 +
 rtl/tff_cell.sv | 34 +++
 rtl/tff_timer_ctrl.sv | 112 +++++++++++
 tb/tb_tff_timer_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tff_timer_ctrl_pkg.sv
// rtl/tff_timer_ctrl_pkg.sv - shared state encodings and limits for the toggle-cell interval timer
//
// Purpose : State encoding for the timer controller and the legal WIDTH range.
//           2'b11 is not a named state; the controller treats it as illegal
//           and recovers to ST_IDLE on the next edge.
// Ports   : none (package)
package tff_timer_ctrl_pkg;

  localparam int unsigned TIMER_WIDTH_MIN = 2;
  localparam int unsigned TIMER_WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_EXPIRE = 2'b10
  } timer_state_t;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - one loadable toggle flip-flop bit
//
// Purpose : Single counter bit. Next state is i_din when i_load, else o_q ^ i_en.
//           Load has priority over toggle.
// Ports   : i_clk    rising-edge clock
//           i_rst_n  asynchronous active-low reset (o_q -> 0)
//           i_en     toggle enable
//           i_load   data-select
//           i_din    load data
//           o_q      cell state
module tff_cell (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_load,
  input  logic i_din,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_load) begin
      r_q <= i_din;
    end else begin
      r_q <= r_q ^ i_en;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tff_timer_ctrl.sv
// rtl/tff_timer_ctrl.sv - down-counting interval timer: controller plus a chain of toggle cells
//
// Purpose : Loads i_preload into a chain of tff_cell bits, counts down once per
//           clock, and raises o_done for one cycle per expiry (held while
//           auto-reloading a zero preload). One-shot or auto-reload.
//           Edge priority: i_stop > i_start > normal sequencing.
// Ports   : i_clk          rising-edge clock
//           i_rst_n        asynchronous active-low reset
//           i_start        start / restart from i_preload
//           i_stop         halt, return to idle, count freezes
//           i_auto_reload  reload on expiry when 1, one-shot when 0
//           i_preload      start value, sampled on load edges only
//           o_count        current count (cell outputs)
//           o_busy         high in RUN or EXPIRE
//           o_done         high in EXPIRE
// WIDTH must lie in TIMER_WIDTH_MIN..TIMER_WIDTH_MAX.
module tff_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_auto_reload,
  input  logic [WIDTH-1:0] i_preload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done
);

  import tff_timer_ctrl_pkg::*;

  timer_state_t     r_state;
  timer_state_t     w_state_nxt;
  logic             w_load;
  logic             w_count_en;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_count_en  = 1'b0;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (i_start) begin
      w_load      = 1'b1;
      w_state_nxt = (i_preload != '0) ? ST_RUN : ST_EXPIRE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          // RUN is always left at zero, so the zero guard only protects
          // against wrapping if the chain was somehow disturbed.
          w_count_en = (w_count != '0);
          if (w_count <= WIDTH'(1)) begin
            w_state_nxt = ST_EXPIRE;
          end
        end
        ST_EXPIRE: begin
          if (i_auto_reload) begin
            w_load      = 1'b1;
            w_state_nxt = (i_preload != '0) ? ST_RUN : ST_EXPIRE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Decrement as a ripple of toggle enables: bit i flips when every lower
  // bit is currently 0 (a borrow propagates through them).
  always_comb begin
    logic v_lower_zero;
    v_lower_zero = 1'b1;
    w_toggle     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_toggle[i]  = w_count_en & v_lower_zero;
      v_lower_zero = v_lower_zero & ~w_count[i];
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell u_cell (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_toggle[gi]),
      .i_load  (w_load),
      .i_din   (i_preload[gi]),
      .o_q     (w_count[gi])
    );
  end

  assign o_count = w_count;
  assign o_busy  = (r_state == ST_RUN) || (r_state == ST_EXPIRE);
  assign o_done  = (r_state == ST_EXPIRE);

endmodule

// File: tb/tb_tff_timer_ctrl.sv
// tb/tb_tff_timer_ctrl.sv - self-checking bench for tff_timer_ctrl
module tb_tff_timer_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         ar;
  logic [W-1:0] pre;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  // Reference: phase 0 = idle, 1 = counting, 2 = expired
  int m_cnt = 0;
  int m_ph  = 0;

  always #5 clk = ~clk;

  tff_timer_ctrl #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_stop        (stop),
    .i_auto_reload (ar),
    .i_preload     (pre),
    .o_count       (cnt),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_model(input int v);
    m_cnt = v;
    m_ph  = (v != 0) ? 1 : 2;
  endtask

  // Behaviour of one rising edge, from the timer rules
  task automatic model_edge();
    if (!rst_n) begin
      m_cnt = 0;
      m_ph  = 0;
    end else if (stop) begin
      m_ph = 0;
    end else if (start) begin
      load_model(int'(pre));
    end else if (m_ph == 1) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_ph = 2;
    end else if (m_ph == 2) begin
      if (ar) load_model(int'(pre));
      else    m_ph = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".count"}, 32'(cnt),  32'(m_cnt));
    check({tag, ".busy"},  32'(busy), 32'(m_ph != 0));
    check({tag, ".done"},  32'(done), 32'(m_ph == 2));
  endtask

  task automatic step(input string tag, input logic s, input logic p,
                      input logic a, input logic [W-1:0] d);
    start = s;
    stop  = p;
    ar    = a;
    pre   = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  initial begin
    int guard;
    int done_cnt;
    logic a_rand;

    rst_n = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    ar    = 1'b0;
    pre   = 8'd5;

    // Reset held while start pulses
    #1;
    check("rst.count", 32'(cnt), 32'd0);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.done",  32'(done), 32'd0);
    repeat (3) step("rst_hold", 1'b1, 1'b0, 1'b0, 8'd5);
    #2 rst_n = 1'b1;

    // One-shot, preload 3
    step("os_idle", 1'b0, 1'b0, 1'b0, 8'd3);
    step("os_load", 1'b1, 1'b0, 1'b0, 8'd3);
    check("os_first", 32'(cnt), 32'd3);
    done_cnt = 0;
    repeat (6) begin
      step("os_run", 1'b0, 1'b0, 1'b0, 8'd9);
      if (done) done_cnt++;
    end
    check("os_done_pulses", 32'(done_cnt), 32'd1);

    // Auto-reload, preload 4: done every 5 cycles
    step("ar_load", 1'b1, 1'b0, 1'b1, 8'd4);
    done_cnt = 0;
    repeat (15) begin
      step("ar_run", 1'b0, 1'b0, 1'b1, 8'd4);
      if (done) done_cnt++;
    end
    check("ar_done_pulses", 32'(done_cnt), 32'd3);
    step("ar_stop", 1'b0, 1'b1, 1'b0, 8'd4);

    // Stop beats start at count 6
    step("sp_load", 1'b1, 1'b0, 1'b0, 8'd10);
    guard = 0;
    while (m_cnt != 6 && guard < 20) begin
      step("sp_run", 1'b0, 1'b0, 1'b0, 8'd10);
      guard++;
    end
    check("sp_reach6", 32'(guard < 20), 32'd1);
    step("sp_both", 1'b1, 1'b1, 1'b0, 8'd10);
    check("sp_frozen", 32'(cnt), 32'd6);
    repeat (3) step("sp_idle", 1'b0, 1'b0, 1'b0, 8'd10);

    // Restart at count 2 with preload 7
    step("rs_load", 1'b1, 1'b0, 1'b0, 8'd9);
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin
      step("rs_run", 1'b0, 1'b0, 1'b0, 8'd7);
      guard++;
    end
    step("rs_restart", 1'b1, 1'b0, 1'b0, 8'd7);
    check("rs_seven", 32'(cnt), 32'd7);
    repeat (9) step("rs_run2", 1'b0, 1'b0, 1'b0, 8'd7);

    // Zero preload: one-shot, then auto-reload holding done
    step("z_os", 1'b1, 1'b0, 1'b0, 8'd0);
    check("z_os_done", 32'(done), 32'd1);
    step("z_os_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    step("z_ar", 1'b1, 1'b0, 1'b1, 8'd0);
    repeat (4) begin
      step("z_ar_hold", 1'b0, 1'b0, 1'b1, 8'd0);
      check("z_ar_done", 32'(done), 32'd1);
    end
    step("z_ar_stop", 1'b0, 1'b1, 1'b1, 8'd0);

    // Asynchronous reset mid-run at count 5
    step("ay_load", 1'b1, 1'b0, 1'b0, 8'd200);
    guard = 0;
    while (m_cnt != 5 && guard < 300) begin
      step("ay_run", 1'b0, 1'b0, 1'b0, 8'd200);
      guard++;
    end
    check("ay_reach5", 32'(cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("ay_count", 32'(cnt), 32'd0);
    check("ay_busy",  32'(busy), 32'd0);
    check("ay_done",  32'(done), 32'd0);
    m_cnt = 0;
    m_ph  = 0;
    #2 rst_n = 1'b1;
    step("ay_after", 1'b0, 1'b0, 1'b0, 8'd200);

    // Randomized sequencing against the reference
    a_rand = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic         s_r;
      logic         p_r;
      logic [W-1:0] d_r;
      s_r = ($urandom_range(0, 9) == 0);
      p_r = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 19) == 0) a_rand = ~a_rand;
      if ($urandom_range(0, 4) == 0) d_r = W'($urandom_range(0, 2));
      else                            d_r = W'($urandom_range(0, 24));
      step("rnd", s_r, p_r, a_rand, d_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
